piso_shifter: RTL
=================

// Module: piso_shifter
// PURPOSE
//   Parallel-in/serial-out shift stage. Accepts a WIDTH-bit word with a valid/ready
//   handshake and streams it LSB-first, one bit per clock, on oSerial. Sits directly
//   upstream of the mux cell: oSerial drives the mux data input, oSerialValid qualifies it.
//   Built on the same ffd/gate library, one clock domain.
// PARAMETERS
//   WIDTH   8   data word width in bits (>=2)
//   CNT_W   3   bit-counter width; must satisfy 2**CNT_W >= WIDTH
// PORTS
//   iClk          in   1       clock, all state updates on posedge
//   iClr          in   1       reset, asynchronous, active-high
//   iData         in   WIDTH   parallel word, sampled only on the accept edge
//   iValid        in   1       word on iData is valid
//   oReady        out  1       block can accept a word this cycle
//   iHold         in   1       stall: freeze shifting while high
//   oSerial       out  1       serial data bit, LSB first
//   oSerialValid  out  1       oSerial carries a data or parity bit
//   oDone         out  1       one-cycle pulse after the last bit
// BEHAVIOUR
//   Reset: iClr=1 forces state IDLE, shift reg=0, count=0, oSerial=0, oSerialValid=0,
//     oDone=0, oReady=0. This takes effect immediately, without waiting for a clock edge.
//     oReady=1 from the first cycle after iClr falls.
//   States: IDLE, SHIFT, PARITY (only with the macro), DONE.
//   IDLE: oReady=1. On a posedge with iValid=1, load iData, set count=0 and go to SHIFT.
//     Without iValid, stay in IDLE.
//   SHIFT: oSerial=shreg[0] and oSerialValid=1.
//     - Posedge with iHold=0: shift right by one and increment count.
//     - If count==WIDTH-1 at that edge: go to PARITY if enabled, else DONE.
//     - iHold=1: shift reg, count and state are all frozen; oSerial holds its value.
//   DONE: oDone=1, oReady=0, oSerialValid=0, oSerial=0. Next edge goes to IDLE unconditionally.
//   Latency, no hold: word accepted at edge N.
//     - Bit k is on oSerial during cycle N+1+k.
//     - oDone is high in cycle N+WIDTH+1.
//     - oReady is high again in cycle N+WIDTH+2.
//   Throughput: one word per WIDTH+2 cycles.
//   Outside SHIFT/PARITY: oSerial=0 and oSerialValid=0.
//   iValid while oReady=0 is ignored; no word is queued. Changes on iData after the
//     accept edge have no effect.
//   iHold in IDLE or DONE has no effect.
//   Reset mid-operation: the word is aborted and no oDone is produced.
//   oReady, oSerialValid and oDone are decoded from the state register only;
//     they have no combinational path from the inputs.
// CONFIGURATION
//   PISO_PARITY_EN defined:
//     - After the last data bit, a PARITY state lasts one cycle (extended by iHold).
//     - oSerial = even parity (XOR of the loaded word), oSerialValid=1.
//     - Then DONE. Latency grows by 1: oDone in cycle N+WIDTH+2.
//   PISO_PARITY_EN undefined: the PARITY state and its logic are not compiled;
//     SHIFT goes directly to DONE.
// TESTING
//   1 Reset: iClr=1 during bit 3 of 8'hA5 -> oSerial=0, oSerialValid=0 immediately;
//     no oDone pulse; oReady=1 in the first cycle after iClr=0.
//   2 Basic: 8'hA5 accepted at edge N, iHold=0 -> oSerial 1,0,1,0,0,1,0,1 in cycles
//     N+1..N+8; oDone=1 only in cycle N+9; oReady=1 in cycle N+10.
//   3 Stall: 8'h3C, iHold=1 for 3 cycles while bit 3 is on oSerial -> bit 3 (=1) held
//     for 4 cycles; oSerialValid high for 11 cycles; oDone in cycle N+12.
//   4 Busy ignore: during 8'h0F, iValid=1 with iData=8'hFF for 2 cycles -> no effect;
//     the output stream stays 1,1,1,1,0,0,0,0.
//   5 Back-to-back: iValid held high, iData=8'h01 then 8'h80 -> second word accepted on
//     the first IDLE edge; exactly one DONE cycle between the two words; streams correct.
//   6 PISO_PARITY_EN: 8'h07 -> 9th bit 1; 8'h03 -> 9th bit 0; oDone in cycle N+10.

Source files
------------

// File: rtl/piso_shifter.sv
// piso_shifter
//   Parallel-in/serial-out shift stage. Accepts a WIDTH-bit word on a valid/ready
//   handshake and streams it LSB-first, one bit per clock, on oSerial. oSerialValid
//   qualifies each data (or parity) bit, and oDone pulses for one cycle after the
//   last bit.
//
//   Optional feature macro: PISO_PARITY_EN
//     defined   : one extra PARITY bit (XOR of the loaded word) follows the data bits
//     undefined : SHIFT goes straight to DONE; no parity logic is built
//
//   Ports
//     iClk          in   1      clock, all state updates on posedge
//     iClr          in   1      asynchronous active-high reset
//     iData         in   WIDTH  parallel word, sampled on the accept edge only
//     iValid        in   1      iData is valid
//     oReady        out  1      block can accept a word this cycle
//     iHold         in   1      freeze shifting while high (SHIFT/PARITY only)
//     oSerial       out  1      serial bit, LSB first
//     oSerialValid  out  1      oSerial carries a data or parity bit
//     oDone         out  1      one-cycle pulse after the last bit
//
//   state  | meaning
//   IDLE   | waiting for a word, oReady high (once out of reset)
//   SHIFT  | data bit shreg_q[0] on oSerial
//   PARITY | parity bit on oSerial (PISO_PARITY_EN only)
//   DONE   | one-cycle completion pulse, then back to IDLE

module piso_shifter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             iClk,
    input  logic             iClr,
    input  logic [WIDTH-1:0] iData,
    input  logic             iValid,
    output logic             oReady,
    input  logic             iHold,
    output logic             oSerial,
    output logic             oSerialValid,
    output logic             oDone
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
`ifdef PISO_PARITY_EN
        ST_PARITY = 2'd2,
`endif
        ST_DONE   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Held low through reset and set on the first clock edge afterwards, so oReady
    // comes up in the first cycle after iClr falls without decoding iClr itself.
    logic               rdy_arm_q, rdy_arm_d;
`ifdef PISO_PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic accept;
    logic last_bit;

    assign accept   = (state_q == ST_IDLE) && rdy_arm_q && iValid;
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // State and datapath registers
    always_ff @(posedge iClk or posedge iClr) begin
        if (iClr) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            rdy_arm_q <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            rdy_arm_q <= rdy_arm_d;
`ifdef PISO_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (!iHold && last_bit) begin
`ifdef PISO_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                if (!iHold) state_d = ST_DONE;
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        rdy_arm_d = 1'b1;
`ifdef PISO_PARITY_EN
        parity_d  = parity_q;
`endif
        if (accept) begin
            shreg_d  = iData;
            cnt_d    = '0;
`ifdef PISO_PARITY_EN
            parity_d = ^iData;
`endif
        end else if (state_q == ST_SHIFT && !iHold) begin
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            cnt_d   = cnt_q + 1'b1;
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        oReady       = 1'b0;
        oSerial      = 1'b0;
        oSerialValid = 1'b0;
        oDone        = 1'b0;
        case (state_q)
            ST_IDLE:  oReady = rdy_arm_q;
            ST_SHIFT: begin
                oSerial      = shreg_q[0];
                oSerialValid = 1'b1;
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                oSerial      = parity_q;
                oSerialValid = 1'b1;
            end
`endif
            ST_DONE:  oDone = 1'b1;
            default: ;
        endcase
    end

endmodule
